// File: rtl/matrix_pingpong_buffer.sv
// Two-bank ping-pong tile buffer: the producer fills the shadow bank element by element
// while the consumer reads whole rows from the active bank; banks swap on a gated handshake.
module matrix_pingpong_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned NUM_COLS   = 4,
  parameter bit          AUTO_SWAP  = 1'b0,
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int unsigned NW = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [RW-1:0]                  wr_row,
  input  logic [CW-1:0]                  wr_col,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_err,
  output logic [NW-1:0]                  shadow_count,
  output logic                           shadow_full,
  input  logic                           swap_req,
  output logic                           swap_done,
  output logic                           active_valid,
  input  logic                           rd_en,
  input  logic [RW-1:0]                  rd_row,
  output logic                           rd_valid,
  output logic [DATA_WIDTH*NUM_COLS-1:0] rd_data_flat,
  input  logic                           rd_release
);

  localparam int unsigned NE = NUM_ROWS * NUM_COLS;
  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

  logic [DATA_WIDTH-1:0]          mem_q [2][NE];
  logic [DATA_WIDTH-1:0]          mem_d [2][NE];
  logic [NE-1:0]                  fill_q, fill_d;
  logic [NW-1:0]                  shadow_count_q, shadow_count_d;
  logic                           shadow_full_q, shadow_full_d;
  logic                           active_sel_q, active_sel_d;
  logic                           active_valid_q, active_valid_d;
  logic                           swap_pending_q, swap_pending_d;
  logic                           swap_done_q, swap_done_d;
  logic                           wr_err_q, wr_err_d;
  logic                           rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH*NUM_COLS-1:0] rd_data_q, rd_data_d;

  logic          wr_fire, wr_oor, swap_fire, rd_fire;
  logic [IW-1:0] wr_idx;

  // Next-state: write into shadow, swap/release of the active tile, row read
  always_comb begin
    mem_d          = mem_q;
    fill_d         = fill_q;
    shadow_count_d = shadow_count_q;
    active_sel_d   = active_sel_q;
    active_valid_d = active_valid_q;
    swap_pending_d = swap_pending_q;
    rd_data_d      = rd_data_q;

    wr_oor    = (32'(wr_row) >= NUM_ROWS) || (32'(wr_col) >= NUM_COLS);
    wr_idx    = IW'(32'(wr_row) * NUM_COLS + 32'(wr_col));
    wr_fire   = wr_valid && !shadow_full_q;
    swap_fire = shadow_full_q && !active_valid_q && (swap_pending_q || AUTO_SWAP);
    rd_fire   = rd_en && active_valid_q;

    wr_err_d    = wr_fire && wr_oor;
    swap_done_d = swap_fire;
    rd_valid_d  = rd_fire;

    if (wr_fire && !wr_oor) begin
      mem_d[~active_sel_q][wr_idx] = wr_data;
      if (!fill_q[wr_idx]) begin
        fill_d[wr_idx] = 1'b1;
        shadow_count_d = shadow_count_q + NW'(1);
      end
    end

    // Swap needs a full shadow, so it never coincides with an accepted write
    if (swap_fire) begin
      active_sel_d   = ~active_sel_q;
      active_valid_d = 1'b1;
      fill_d         = '0;
      shadow_count_d = '0;
      swap_pending_d = 1'b0;
    end else begin
      if (swap_req && !AUTO_SWAP) swap_pending_d = 1'b1;
      if (rd_release) active_valid_d = 1'b0;
    end

    shadow_full_d = (shadow_count_d == NW'(NE));

    if (rd_fire) begin
      rd_data_d = '0;
      if (32'(rd_row) < NUM_ROWS) begin
        for (int c = 0; c < int'(NUM_COLS); c++) begin
          rd_data_d[c*DATA_WIDTH +: DATA_WIDTH] =
            mem_q[active_sel_q][IW'(32'(rd_row) * NUM_COLS + 32'(c))];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(NE); i++) mem_q[b][i] <= '0;
      end
      fill_q         <= '0;
      shadow_count_q <= '0;
      shadow_full_q  <= 1'b0;
      active_sel_q   <= 1'b0;
      active_valid_q <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      wr_err_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      mem_q          <= mem_d;
      fill_q         <= fill_d;
      shadow_count_q <= shadow_count_d;
      shadow_full_q  <= shadow_full_d;
      active_sel_q   <= active_sel_d;
      active_valid_q <= active_valid_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      wr_err_q       <= wr_err_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign wr_ready     = ~shadow_full_q;
  assign shadow_full  = shadow_full_q;
  assign shadow_count = shadow_count_q;
  assign wr_err       = wr_err_q;
  assign swap_done    = swap_done_q;
  assign active_valid = active_valid_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data_flat = rd_data_q;

endmodule

// File: doc/matrix_pingpong_buffer.md
# matrix_pingpong_buffer

Parametrised two-bank (ping-pong) matrix buffer for the vector datapath. It generalises the single-vector double buffer to a NUM_ROWS × NUM_COLS tile with row/column addressing, per-entry fill tracking and a gated swap handshake. A producer fills the shadow bank one element per cycle while the compute array reads whole rows from the active bank. Banks swap only when the shadow tile is complete and the consumer has released the active tile.

## Interface

Parameters:
- DATA_WIDTH, 8, bits per element
- NUM_ROWS, 4, rows per tile
- NUM_COLS, 4, columns per tile (row read width)
- AUTO_SWAP, 0, 1 = swap without swap_req once the swap conditions hold

Ports (RW = $clog2(NUM_ROWS), CW = $clog2(NUM_COLS), NW = $clog2(NUM_ROWS*NUM_COLS+1)):
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  shadow bank accepts writes
- wr_row  in  RW  write row address
- wr_col  in  CW  write column address
- wr_data  in  DATA_WIDTH  write element
- wr_err  out  1  one-cycle pulse: accepted write had an out-of-range address
- shadow_count  out  NW  distinct shadow entries written
- shadow_full  out  1  shadow_count == NUM_ROWS*NUM_COLS
- swap_req  in  1  swap request pulse (ignored when AUTO_SWAP=1)
- swap_done  out  1  one-cycle pulse in the cycle after a swap
- active_valid  out  1  active bank holds an unreleased complete tile
- rd_en  in  1  row read request
- rd_row  in  RW  read row address
- rd_valid  out  1  rd_data_flat valid
- rd_data_flat  out  DATA_WIDTH*NUM_COLS  row; column c at [c*DATA_WIDTH +: DATA_WIDTH]
- rd_release  in  1  consumer is finished with the active tile

## Operation

- Storage: bank0 and bank1, NUM_ROWS*NUM_COLS elements each, plus a fill bitmap per bank. active_sel selects the read bank; writes go to bank !active_sel.
- Write: fires when wr_valid && wr_ready. wr_ready = !shadow_full.
  - In range: store the element. If the entry's fill bit was clear, set it and increment shadow_count. Rewriting a filled entry updates the data only.
  - Out of range (row >= NUM_ROWS or col >= NUM_COLS, for non-power-of-2 sizes): no storage change; wr_err pulses.
- Swap pending: a swap_req pulse sets swap_pending. With AUTO_SWAP=1, swap_pending is treated as always 1.
- Swap fires when shadow_full && !active_valid && swap_pending, evaluated on registered state. On the swap edge:
  - active_sel toggles and active_valid is set.
  - The new shadow bitmap is cleared and shadow_count goes to 0. Stale data stays and is not zeroed.
  - swap_pending clears.
- The first tile after reset becomes active only through a swap.
- Release: rd_release sets active_valid to 0 at the next edge. rd_release when active_valid=0 has no effect.
- Read: when rd_en && active_valid, rd_data_flat takes row rd_row of the active bank at the next edge and rd_valid=1 for one cycle.
  - rd_en while !active_valid: rd_valid=0 and rd_data_flat holds its value.
  - Out-of-range rd_row: rd_data_flat = 0 with rd_valid=1.
- Reset mid-operation: all state returns to reset values and any tile in flight is discarded.

## Timing

- Reset values: wr_ready=1, wr_err=0, shadow_count=0, shadow_full=0, swap_done=0, active_valid=0, rd_valid=0, rd_data_flat=0, active_sel=0, swap_pending=0, bitmaps and storage cleared.
- Write to shadow_count/shadow_full: 1 cycle. wr_ready falls in the cycle after the final distinct write.
- Swap: the earliest swap edge is the edge after the cycle in which all conditions are true.
  - swap_done and active_valid=1 are visible in the following cycle.
  - swap_req in the same cycle as the final write: the swap occurs 1 edge later.
- rd_release and the swap conditions in the same cycle: active_valid clears on that edge and the swap happens no earlier than the next edge.
- Read latency is 1 cycle. A read issued in the cycle of the swap edge returns the pre-swap bank.
- Sustained throughput: 1 write per cycle plus 1 row read per cycle.

## Test plan

- Reset, then fill 4×4 with data = 16*row+col, then swap_req → swap_done after 1 cycle, active_valid=1, shadow_count=0; reading row 2 returns {0x23,0x22,0x21,0x20}.
- Write (1,1) twice with 0xAA then 0xBB → shadow_count increments once and data is 0xBB; a write after 16 distinct entries sees wr_ready=0 and is not accepted.
- Shadow full while active_valid=1 with swap_req pending → no swap until rd_release; swap_done 2 cycles after the release.
- AUTO_SWAP=1, NUM_ROWS=3: fill → swap with no swap_req; write to row 3 → wr_err pulse and count unchanged; read of row 3 → zeros with rd_valid=1.
- Read issued in the same cycle as the swap edge returns the old tile; rd_en with active_valid=0 → rd_valid stays 0.
- Assert rst mid-fill (count=7) → all outputs at reset values next cycle; a refill of 16 entries is required before any swap.
